// File: rtl/chrono_pkg.sv
// Shared chronometer encodings: arbiter FSM states and access-owner codes.
package chrono_pkg;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] ACCESS = 2'b01;
    localparam logic [1:0] RESP   = 2'b10;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/lap_mem_arbiter_if.sv
// Requester A/B handshakes plus the single-port lap RAM bus. The master view
// belongs to the arbiter; the slave view to the requesters and the RAM.
interface lap_mem_arbiter_if #(
    parameter int ADDR_SIZE = 4,
    parameter int DATA_SIZE = 16
);
    logic                 a_req;
    logic                 a_we;
    logic [ADDR_SIZE-1:0] a_addr;
    logic [DATA_SIZE-1:0] a_wdata;
    logic                 a_gnt;
    logic                 a_rvalid;
    logic [DATA_SIZE-1:0] a_rdata;

    logic                 b_req;
    logic [ADDR_SIZE-1:0] b_addr;
    logic                 b_gnt;
    logic                 b_rvalid;
    logic [DATA_SIZE-1:0] b_rdata;

    logic                 mem_en;
    logic                 mem_we;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [DATA_SIZE-1:0] mem_wdata;
    logic [DATA_SIZE-1:0] mem_rdata;

    modport master (
        input  a_req, a_we, a_addr, a_wdata, b_req, b_addr, mem_rdata,
        output a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output a_req, a_we, a_addr, a_wdata, b_req, b_addr, mem_rdata,
        input  a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/lap_mem_arbiter_rr_arb2.sv
// Two-input winner select. LAP_ARB_RR_EN: ties go to the requester not served
// last; otherwise A always wins ties.
module rr_arb2
    import chrono_pkg::*;
(
    input  logic a_req,
    input  logic b_req,
`ifdef LAP_ARB_RR_EN
    input  logic last_own,
`endif
    output logic win_valid,
    output logic win_own
);

    always_comb begin
        win_valid = a_req | b_req;
`ifdef LAP_ARB_RR_EN
        if (a_req && b_req) begin
            win_own = ~last_own;
        end else begin
            win_own = a_req ? OWN_A : OWN_B;
        end
`else
        win_own = a_req ? OWN_A : OWN_B;
`endif
    end

endmodule

// File: rtl/lap_mem_arbiter.sv
// Lap RAM arbiter: one RAM access per transaction via IDLE/ACCESS/RESP, read data
// routed to the owner, saturating lap counter. Optional macro: LAP_ARB_RR_EN.
module lap_mem_arbiter
    import chrono_pkg::*;
#(
    parameter int ADDR_SIZE = 4,
    parameter int DATA_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    lap_mem_arbiter_if.master    bus,
    output logic [ADDR_SIZE:0]   lap_count
);

    localparam logic [ADDR_SIZE:0] LAP_MAX = {1'b1, {ADDR_SIZE{1'b0}}};
    localparam logic [ADDR_SIZE:0] LAP_ONE = {{ADDR_SIZE{1'b0}}, 1'b1};

    logic [1:0] state;
    logic       owner;
    logic       acc_we;
    logic       win_valid;
    logic       win_own;

`ifdef LAP_ARB_RR_EN
    logic last_own;

    rr_arb2 u_arb (
        .a_req     (bus.a_req),
        .b_req     (bus.b_req),
        .last_own  (last_own),
        .win_valid (win_valid),
        .win_own   (win_own)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            last_own <= OWN_B;
        end else if (state == IDLE && win_valid) begin
            last_own <= win_own;
        end
    end
`else
    rr_arb2 u_arb (
        .a_req     (bus.a_req),
        .b_req     (bus.b_req),
        .win_valid (win_valid),
        .win_own   (win_own)
    );
`endif

    // NOTE: every register here uses <= so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            owner         <= OWN_B;
            acc_we        <= 1'b0;
            bus.a_gnt     <= 1'b0;
            bus.b_gnt     <= 1'b0;
            bus.a_rvalid  <= 1'b0;
            bus.b_rvalid  <= 1'b0;
            bus.a_rdata   <= '0;
            bus.b_rdata   <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            lap_count     <= '0;
        end else begin
            bus.a_gnt    <= 1'b0;
            bus.b_gnt    <= 1'b0;
            bus.a_rvalid <= 1'b0;
            bus.b_rvalid <= 1'b0;
            bus.mem_en   <= 1'b0;
            bus.mem_we   <= 1'b0;

            case (state)
                IDLE: begin
                    if (win_valid) begin
                        state      <= ACCESS;
                        owner      <= win_own;
                        bus.mem_en <= 1'b1;
                        if (win_own == OWN_A) begin
                            acc_we        <= bus.a_we;
                            bus.mem_we    <= bus.a_we;
                            bus.mem_addr  <= bus.a_addr;
                            bus.mem_wdata <= bus.a_wdata;
                            bus.a_gnt     <= 1'b1;
                        end else begin
                            acc_we       <= 1'b0;
                            bus.mem_addr <= bus.b_addr;
                            bus.b_gnt    <= 1'b1;
                        end
                    end
                end
                ACCESS: state <= RESP;
                RESP: begin
                    // RAM output is valid in this cycle only; writes get no rvalid.
                    if (!acc_we) begin
                        if (owner == OWN_A) begin
                            bus.a_rdata  <= bus.mem_rdata;
                            bus.a_rvalid <= 1'b1;
                        end else begin
                            bus.b_rdata  <= bus.mem_rdata;
                            bus.b_rvalid <= 1'b1;
                        end
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Counted in the grant cycle, so clr in that same cycle wins.
            if (clr) begin
                lap_count <= '0;
            end else if (bus.a_gnt && bus.mem_we && lap_count != LAP_MAX) begin
                lap_count <= lap_count + LAP_ONE;
            end
        end
    end

endmodule

// File: tb/tb_lap_mem_arbiter.sv
// Directed bench for lap_mem_arbiter with a behavioural 1-cycle-latency lap RAM.
module tb_lap_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic [4:0] lap_count;
    int         total = 0;
    int         bad = 0;
    logic       exp_b;

    logic [15:0] ram [16] = '{default: 16'h0000};

    lap_mem_arbiter_if #(.ADDR_SIZE(4), .DATA_SIZE(16)) bus ();

    lap_mem_arbiter #(.ADDR_SIZE(4), .DATA_SIZE(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .bus       (bus),
        .lap_count (lap_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a_gnt"},     32'(bus.a_gnt),     0);
        check({tag, "_b_gnt"},     32'(bus.b_gnt),     0);
        check({tag, "_a_rvalid"},  32'(bus.a_rvalid),  0);
        check({tag, "_b_rvalid"},  32'(bus.b_rvalid),  0);
        check({tag, "_a_rdata"},   32'(bus.a_rdata),   0);
        check({tag, "_b_rdata"},   32'(bus.b_rdata),   0);
        check({tag, "_mem_en"},    32'(bus.mem_en),    0);
        check({tag, "_mem_we"},    32'(bus.mem_we),    0);
        check({tag, "_mem_addr"},  32'(bus.mem_addr),  0);
        check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 0);
        check({tag, "_lap_count"}, 32'(lap_count),     0);
    endtask

    // Requester A transaction from IDLE; returns at the next IDLE.
    task automatic a_access(input logic we, input logic [3:0] addr, input logic [15:0] data);
        int n;
        bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = data;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.a_gnt && n < 8);
        check("a_gnt_wait", 32'(bus.a_gnt), 1);
        bus.a_req = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        bus.a_req = 0; bus.a_we = 0; bus.a_addr = 0; bus.a_wdata = 0;
        bus.b_req = 0; bus.b_addr = 0;

        // Reset state
        tick();
        tick();
        check_zero("reset");
        rst = 1'b0;
        tick();

        // A writes 0x0042 to addr 3
        bus.a_req = 1; bus.a_we = 1; bus.a_addr = 4'd3; bus.a_wdata = 16'h0042;
        tick();
        check("wr_a_gnt",     32'(bus.a_gnt),     1);
        check("wr_b_gnt",     32'(bus.b_gnt),     0);
        check("wr_mem_en",    32'(bus.mem_en),    1);
        check("wr_mem_we",    32'(bus.mem_we),    1);
        check("wr_mem_addr",  32'(bus.mem_addr),  3);
        check("wr_mem_wdata", 32'(bus.mem_wdata), 32'h0042);
        bus.a_req = 0;
        tick();
        check("wr_lap_count", 32'(lap_count),     1);
        check("wr_mem_en_drop", 32'(bus.mem_en),  0);
        check("wr_a_gnt_drop",  32'(bus.a_gnt),   0);
        check("wr_a_rvalid_c2", 32'(bus.a_rvalid), 0);
        tick();
        check("wr_a_rvalid_c3", 32'(bus.a_rvalid), 0);

        // B reads back addr 3
        bus.b_req = 1; bus.b_addr = 4'd3;
        tick();
        check("rd_b_gnt",    32'(bus.b_gnt),    1);
        check("rd_mem_we",   32'(bus.mem_we),   0);
        check("rd_mem_addr", 32'(bus.mem_addr), 3);
        bus.b_req = 0;
        tick();
        check("rd_b_rvalid_early", 32'(bus.b_rvalid), 0);
        tick();
        check("rd_b_rvalid", 32'(bus.b_rvalid), 1);
        check("rd_b_rdata",  32'(bus.b_rdata),  32'h0042);
        check("rd_a_rvalid", 32'(bus.a_rvalid), 0);
        tick();
        check("rd_b_rvalid_pulse", 32'(bus.b_rvalid), 0);
        check("rd_b_rdata_hold",   32'(bus.b_rdata),  32'h0042);

        // Tie: both requesters held high; B was served last
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 4'd3;
        bus.b_req = 1; bus.b_addr = 4'd5;
        for (int k = 0; k < 4; k++) begin
            tick();
`ifdef LAP_ARB_RR_EN
            exp_b = (k % 2 == 1);
`else
            exp_b = 1'b0;
`endif
            check("tie_a_gnt", 32'(bus.a_gnt), 32'(!exp_b));
            check("tie_b_gnt", 32'(bus.b_gnt), 32'(exp_b));
            tick();
            if (k == 0) check("tie_a_rvalid_early", 32'(bus.a_rvalid), 0);
            tick();
            if (k == 0) begin
                check("tie_a_rvalid", 32'(bus.a_rvalid), 1);
                check("tie_a_rdata",  32'(bus.a_rdata),  32'h0042);
            end
        end
        bus.a_req = 0; bus.b_req = 0;
        tick();
        tick();

        // 17 writes: count saturates at 16
        for (int i = 0; i < 17; i++) begin
            a_access(1'b1, 4'(i), 16'h0100 + 16'(i));
        end
        check("sat_lap_count", 32'(lap_count), 16);
        tick();
        check("sat_lap_hold", 32'(lap_count), 16);

        // clr pulse
        clr = 1;
        tick();
        clr = 0;
        check("clr_lap_count", 32'(lap_count), 0);

        // clr coincident with a write grant
        bus.a_req = 1; bus.a_we = 1; bus.a_addr = 4'd7; bus.a_wdata = 16'h0077;
        tick();
        check("clrgnt_a_gnt", 32'(bus.a_gnt), 1);
        bus.a_req = 0;
        clr = 1;
        tick();
        clr = 0;
        check("clrgnt_lap_count", 32'(lap_count), 0);
        tick();
        check("clrgnt_lap_hold", 32'(lap_count), 0);
        a_access(1'b1, 4'd8, 16'h0088);
        check("post_clr_lap_count", 32'(lap_count), 1);

        // rst during the ACCESS cycle of a B read
        bus.b_req = 1; bus.b_addr = 4'd3;
        tick();
        check("rst_b_gnt", 32'(bus.b_gnt), 1);
        bus.b_req = 0;
        rst = 1;
        tick();
        rst = 0;
        check_zero("midrst");
        for (int j = 0; j < 3; j++) begin
            tick();
            check("midrst_no_b_rvalid", 32'(bus.b_rvalid), 0);
        end

        // A holds req past its grant: a second grant follows in the next IDLE
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 4'd3;
        tick();
        check("hold_gnt1", 32'(bus.a_gnt), 1);
        tick();
        check("hold_gap1", 32'(bus.a_gnt), 0);
        tick();
        check("hold_gap2",    32'(bus.a_gnt),    0);
        check("hold_rvalid",  32'(bus.a_rvalid), 1);
        check("hold_rdata",   32'(bus.a_rdata),  32'h0103);
        tick();
        check("hold_gnt2", 32'(bus.a_gnt), 1);
        bus.a_req = 0;
        tick();
        tick();
        tick();
        check("hold_no_gnt3", 32'(bus.a_gnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
